alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Hardware initiator for the ALU operand/command interface; the counterpart to ALU_DESIGN, which is the responder.
- Accepts ALU operation requests from an upstream valid/ready port and drives the ALU inputs.
- Waits the command-dependent ALU latency, captures RES and flags, and returns them with a tag on a downstream valid/ready port.
- One operation in flight at a time. Sits between a command source (sequencer/CPU-side logic) and ALU_DESIGN.

Parameters:
- OP_WIDTH, 8, operand width (OPA/OPB)
- CMD_WIDTH, 4, ALU command width
- TAG_WIDTH, 4, request/response tag width
- ALU_LAT, 1, ALU result latency in cycles for non-multiply commands
- MUL_LAT, 2, ALU result latency for multiply commands (MODE=1, CMD=9 or 10)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-low
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  issuer can accept a request
- REQ_OPA  in  OP_WIDTH  operand A
- REQ_OPB  in  OP_WIDTH  operand B
- REQ_CMD  in  CMD_WIDTH  command
- REQ_MODE  in  1  1=arithmetic, 0=logical
- REQ_CIN  in  1  carry in
- REQ_INP_VALID  in  2  operand valid bits {B,A}
- REQ_TAG  in  TAG_WIDTH  request tag
- OPA, OPB  out  OP_WIDTH  to ALU
- CMD  out  CMD_WIDTH  to ALU
- MODE, CIN, CE  out  1  to ALU
- INP_VALID  out  2  to ALU
- RES  in  2*OP_WIDTH  from ALU
- COUT, OFLOW, G, E, L, ERR  in  1  from ALU flags
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  downstream accepts response
- RSP_RES  out  2*OP_WIDTH  captured result
- RSP_FLAGS  out  6  {ERR,L,E,G,OFLOW,COUT}
- RSP_TAG  out  TAG_WIDTH  echoed tag
- OP_COUNT  out  16  issued-operation count
- ERR_COUNT  out  16  responses with ERR=1

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; every ALU-side output is 0 (CE=0, INP_VALID=2'b00); RSP_VALID=0; RSP_RES, RSP_FLAGS, RSP_TAG = 0; OP_COUNT and ERR_COUNT = 0.
  - Reset mid-operation aborts the operation; no response is produced.
- All outputs are registered. REQ_READY = (state==IDLE) and is decoded from state only.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on REQ_VALID & REQ_READY at edge k:
  - Latch the ALU inputs from the REQ_* fields; CE=1.
  - Load the latency counter with MUL_LAT if MODE=1 and CMD is 9 or 10, else ALU_LAT.
  - Latch the tag; increment OP_COUNT (saturates at 16'hFFFF); go to WAIT.
- IDLE, REQ_INP_VALID=2'b00 at accept:
  - Nothing is driven to the ALU (CE stays 0). OP_COUNT is not incremented.
  - Go directly to RESP next edge with RSP_RES=0, RSP_FLAGS=6'b100000, and ERR_COUNT incremented.
- WAIT: ALU inputs are held stable. The counter decrements each edge. At the edge where the counter is 0:
  - Capture RES and the flags into RSP_*; RSP_VALID=1.
  - Set CE=0 and INP_VALID=2'b00; go to RESP.
  - Increment ERR_COUNT if ERR=1.
- Latency: RSP_VALID rises at edge k+lat+1; with defaults, 2 cycles after accept for ADD and 3 for multiply.
- RESP: RSP_* are held stable while RSP_VALID=1 & RSP_READY=0. On handshake: RSP_VALID=0 next edge, return to IDLE.
  - REQ_READY is low during RESP, so there is no simultaneous accept. Minimum request-to-request spacing is lat+3 cycles.
- REQ_* inputs are ignored outside IDLE. Both counters saturate and never wrap.
- RSP_RES width is 2*OP_WIDTH; results are captured unmodified, with no sign or width manipulation.

Decomposition:
- Shared package alu_pkg (built on defines.sv) holds:
  - command codes: ADD=0, CMP=8, INC_MUL=9, SHL_MUL=10;
  - flag bit indices for RSP_FLAGS;
  - state enum {IDLE, WAIT, RESP};
  - function is_mul(mode,cmd).
- No sub-module; the latency counter is about 3 bits and inline.

Test Plan:
- ADD: REQ MODE=1, CMD=0, OPA=200, OPB=100, INP_VALID=11, CIN=0, TAG=5 -> RSP_VALID 2 cycles after accept, RSP_RES=300, COUT=1, RSP_TAG=5, OP_COUNT=1.
- CMP: MODE=1, CMD=8, OPA=7, OPB=7 -> RSP_FLAGS E=1 with G=L=0; then OPA=9, OPB=3 -> G=1.
- Multiply: MODE=1, CMD=9, OPA=3, OPB=4 -> RSP_VALID 3 cycles after accept, RSP_RES=20. CE, INP_VALID and OPA/OPB stay stable through WAIT.
- Backpressure: RSP_READY=0 for 5 cycles -> RSP_* stable, REQ_READY=0, and a second REQ_VALID is not accepted; RSP_READY=1 -> IDLE next edge, then the second request is accepted.
- Illegal: INP_VALID=00, TAG=3 -> no CE pulse, response next cycle with RSP_FLAGS=6'b100000 and TAG=3, ERR_COUNT=1, OP_COUNT unchanged.
- Reset: drop RST low during WAIT -> all outputs 0 immediately (asynchronously), state IDLE, no response after release; next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/command issuer: command codes,
// response flag layout, issuer state encoding and small helpers.
package alu_pkg;

  localparam logic [3:0] CMD_ADD     = 4'd0;
  localparam logic [3:0] CMD_CMP     = 4'd8;
  localparam logic [3:0] CMD_INC_MUL = 4'd9;
  localparam logic [3:0] CMD_SHL_MUL = 4'd10;

  // Bit positions inside RSP_FLAGS = {ERR,L,E,G,OFLOW,COUT}
  localparam int FLAG_COUT  = 0;
  localparam int FLAG_OFLOW = 1;
  localparam int FLAG_G     = 2;
  localparam int FLAG_E     = 3;
  localparam int FLAG_L     = 4;
  localparam int FLAG_ERR   = 5;

  localparam logic [5:0] FLAGS_ILLEGAL = 6'b1 << FLAG_ERR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_mul(input logic mode, input logic [15:0] cmd);
    return mode && ((cmd == {12'd0, CMD_INC_MUL}) || (cmd == {12'd0, CMD_SHL_MUL}));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation at a time: latches a request onto the ALU inputs,
// waits the command-dependent latency, then returns result, flags and tag.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TAG_WIDTH = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [OP_WIDTH-1:0]   REQ_OPA,
  input  logic [OP_WIDTH-1:0]   REQ_OPB,
  input  logic [CMD_WIDTH-1:0]  REQ_CMD,
  input  logic                  REQ_MODE,
  input  logic                  REQ_CIN,
  input  logic [1:0]            REQ_INP_VALID,
  input  logic [TAG_WIDTH-1:0]  REQ_TAG,
  output logic [OP_WIDTH-1:0]   OPA,
  output logic [OP_WIDTH-1:0]   OPB,
  output logic [CMD_WIDTH-1:0]  CMD,
  output logic                  MODE,
  output logic                  CIN,
  output logic                  CE,
  output logic [1:0]            INP_VALID,
  input  logic [2*OP_WIDTH-1:0] RES,
  input  logic                  COUT,
  input  logic                  OFLOW,
  input  logic                  G,
  input  logic                  E,
  input  logic                  L,
  input  logic                  ERR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [2*OP_WIDTH-1:0] RSP_RES,
  output logic [5:0]            RSP_FLAGS,
  output logic [TAG_WIDTH-1:0]  RSP_TAG,
  output logic [15:0]           OP_COUNT,
  output logic [15:0]           ERR_COUNT
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [TAG_WIDTH-1:0] tag;
  logic                 mul_req;
  logic                 no_operands;

  assign mul_req     = is_mul(REQ_MODE, 16'(REQ_CMD));
  assign no_operands = (REQ_INP_VALID == 2'b00);
  assign REQ_READY   = (state == IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (REQ_VALID) next_state = no_operands ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (RSP_READY) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OPA       <= '0;
      OPB       <= '0;
      CMD       <= '0;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      CE        <= 1'b0;
      INP_VALID <= 2'b00;
      cnt       <= '0;
      tag       <= '0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
      RSP_TAG   <= '0;
      OP_COUNT  <= '0;
      ERR_COUNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            tag <= REQ_TAG;
            // A request with no valid operands never reaches the ALU
            if (no_operands) begin
              RSP_RES   <= '0;
              RSP_FLAGS <= FLAGS_ILLEGAL;
              RSP_TAG   <= REQ_TAG;
              RSP_VALID <= 1'b1;
              ERR_COUNT <= sat_inc(ERR_COUNT);
            end else begin
              OPA       <= REQ_OPA;
              OPB       <= REQ_OPB;
              CMD       <= REQ_CMD;
              MODE      <= REQ_MODE;
              CIN       <= REQ_CIN;
              INP_VALID <= REQ_INP_VALID;
              CE        <= 1'b1;
              cnt       <= mul_req ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
              OP_COUNT  <= sat_inc(OP_COUNT);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            RSP_RES   <= RES;
            RSP_FLAGS <= {ERR, L, E, G, OFLOW, COUT};
            RSP_TAG   <= tag;
            RSP_VALID <= 1'b1;
            CE        <= 1'b0;
            INP_VALID <= 2'b00;
            if (ERR) ERR_COUNT <= sat_inc(ERR_COUNT);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) RSP_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer with a behavioural ALU that only presents
// a correct result on the exact latency cycle.
module tb_alu_op_issuer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID, REQ_READY;
  logic [7:0]  REQ_OPA, REQ_OPB;
  logic [3:0]  REQ_CMD;
  logic        REQ_MODE, REQ_CIN;
  logic [1:0]  REQ_INP_VALID;
  logic [3:0]  REQ_TAG;
  logic [7:0]  OPA, OPB;
  logic [3:0]  CMD;
  logic        MODE, CIN, CE;
  logic [1:0]  INP_VALID;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;
  logic        RSP_VALID, RSP_READY;
  logic [15:0] RSP_RES;
  logic [5:0]  RSP_FLAGS;
  logic [3:0]  RSP_TAG;
  logic [15:0] OP_COUNT, ERR_COUNT;

  always #5 CLK = ~CLK;

  alu_op_issuer dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
    .REQ_TAG(REQ_TAG),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
    .INP_VALID(INP_VALID),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS), .RSP_TAG(RSP_TAG),
    .OP_COUNT(OP_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  typedef struct {
    logic [15:0] res;
    logic [5:0]  flags;
    logic [3:0]  tag;
    int          dly;
    int          acc;
    logic [7:0]  opa, opb;
    logic [3:0]  cmd;
    logic [1:0]  iv;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_op = 0;
  int          exp_err = 0;
  logic [15:0] last_res;
  logic [5:0]  last_flags;
  logic [3:0]  last_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: returns {flags[5:0], res[15:0]}, flags = {ERR,L,E,G,OFLOW,COUT}
  function automatic logic [21:0] alu_model(input logic mode, input logic [3:0] cmd,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [5:0]  f;
    logic [7:0]  a2;
    r = 16'd0;
    f = 6'd0;
    a2 = a << 1;
    if (mode) begin
      case (cmd)
        4'd0:  begin r = {8'd0, a} + {8'd0, b}; f[0] = r[8]; end
        4'd8:  begin f[3] = (a == b); f[2] = (a > b); f[4] = (a < b); end
        4'd9:  r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
        4'd10: r = {8'd0, a2} * {8'd0, b};
        4'd15: f[5] = 1'b1;
        default: r = 16'd0;
      endcase
    end else begin
      r = (cmd == 4'd0) ? {8'd0, a & b} : {8'd0, a ^ b};
    end
    return {f, r};
  endfunction

  function automatic int exp_lat(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 2 : 1;
  endfunction

  // Behavioural ALU: correct outputs only on the cycle matching its latency
  int          age = 0;
  logic [21:0] alu_out;
  logic        alu_ok;
  assign alu_out = alu_model(MODE, CMD, OPA, OPB);
  assign alu_ok  = CE && (age == exp_lat(MODE, CMD));
  assign RES     = alu_ok ? alu_out[15:0] : 16'hBAD0;
  assign {ERR, L, E, G, OFLOW, COUT} = alu_ok ? alu_out[21:16] : 6'b111111;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
    age <= CE ? age + 1 : 0;
  end

  // Response monitor / scoreboard checker
  initial begin
    logic prev_valid;
    int   ce_cnt;
    prev_valid = 1'b0;
    ce_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_valid = 1'b0;
        ce_cnt = 0;
      end else begin
        if (CE) begin
          ce_cnt++;
          if (sb.size() == 0) chk("ce_orphan", CE, 0);
          else begin
            chk("hold_opa", OPA, sb[0].opa);
            chk("hold_opb", OPB, sb[0].opb);
            chk("hold_cmd", CMD, sb[0].cmd);
            chk("hold_iv", INP_VALID, sb[0].iv);
          end
        end
        if (RSP_VALID) begin
          if (sb.size() == 0) chk("rsp_orphan", RSP_VALID, 0);
          else begin
            if (!prev_valid) chk("rsp_latency", cyc - sb[0].acc, sb[0].dly);
            chk("rsp_res", RSP_RES, sb[0].res);
            chk("rsp_flags", RSP_FLAGS, sb[0].flags);
            chk("rsp_tag", RSP_TAG, sb[0].tag);
            if (RSP_READY) begin
              chk("ce_cycles", ce_cnt, sb[0].dly);
              ce_cnt = 0;
              last_res = RSP_RES;
              last_flags = RSP_FLAGS;
              last_tag = RSP_TAG;
              $display("rsp tag=%0d res=%0d flags=%b", RSP_TAG, RSP_RES, RSP_FLAGS);
              void'(sb.pop_front());
            end
          end
        end
        prev_valid = RSP_VALID;
      end
    end
  end

  task automatic send(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] iv, input logic [3:0] tag);
    exp_t        e;
    logic [21:0] m;
    int          n;
    @(posedge CLK);
    #1;
    REQ_MODE = mode; REQ_CMD = cmd; REQ_OPA = a; REQ_OPB = b;
    REQ_INP_VALID = iv; REQ_TAG = tag; REQ_CIN = 1'b0; REQ_VALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 60) begin
      n++;
      @(negedge CLK);
    end
    if (!REQ_READY) chk("req_accept_timeout", REQ_READY, 1);
    else begin
      m = alu_model(mode, cmd, a, b);
      e.tag = tag; e.acc = cyc + 1; e.opa = a; e.opb = b; e.cmd = cmd; e.iv = iv;
      if (iv == 2'b00) begin
        e.res = 16'd0; e.flags = 6'b100000; e.dly = 0;
        exp_err++;
      end else begin
        e.res = m[15:0]; e.flags = m[21:16]; e.dly = exp_lat(mode, cmd) + 1;
        exp_op++;
        if (m[21]) exp_err++;
      end
      sb.push_back(e);
      $display("req tag=%0d mode=%0d cmd=%0d a=%0d b=%0d iv=%b", tag, mode, cmd, a, b, iv);
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || RSP_VALID) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_op(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] iv, input logic [3:0] tag);
    send(mode, cmd, a, b, iv, tag);
    wait_idle();
    @(negedge CLK);
    chk("op_count", OP_COUNT, exp_op);
    chk("err_count", ERR_COUNT, exp_err);
  endtask

  initial begin
    int n;
    REQ_VALID = 0; REQ_OPA = 0; REQ_OPB = 0; REQ_CMD = 0; REQ_MODE = 0;
    REQ_CIN = 0; REQ_INP_VALID = 0; REQ_TAG = 0; RSP_READY = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_ce", CE, 0);
    chk("rst_inp_valid", INP_VALID, 0);
    chk("rst_op_count", OP_COUNT, 0);
    chk("rst_err_count", ERR_COUNT, 0);
    chk("rst_req_ready", REQ_READY, 1);
    RST = 1'b1;

    run_op(1, 4'd0, 8'd200, 8'd100, 2'b11, 4'd5);
    chk("add_res", last_res, 300);
    chk("add_cout", last_flags[0], 1);
    chk("add_tag", last_tag, 5);
    chk("add_op_count", OP_COUNT, 1);

    run_op(1, 4'd8, 8'd7, 8'd7, 2'b11, 4'd1);
    chk("cmp_eq_lge", last_flags[4:2], 3'b010);
    run_op(1, 4'd8, 8'd9, 8'd3, 2'b11, 4'd2);
    chk("cmp_gt_lge", last_flags[4:2], 3'b001);

    run_op(1, 4'd9, 8'd3, 8'd4, 2'b11, 4'd3);
    chk("mul_res", last_res, 20);
    run_op(1, 4'd10, 8'd5, 8'd6, 2'b11, 4'd4);
    chk("shl_mul_res", last_res, 60);
    run_op(0, 4'd0, 8'hF0, 8'h3C, 2'b11, 4'd6);
    chk("and_res", last_res, 16'h0030);
    run_op(1, 4'd15, 8'd1, 8'd1, 2'b11, 4'd7);
    chk("alu_err_count", ERR_COUNT, 1);

    // Backpressure with a second request waiting
    RSP_READY = 1'b0;
    send(1, 4'd0, 8'd50, 8'd60, 2'b11, 4'd8);
    fork
      send(1, 4'd8, 8'd1, 8'd2, 2'b11, 4'd9);
      begin
        n = 0;
        while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
        chk("bp_rsp_seen", RSP_VALID, 1);
        repeat (5) begin
          @(negedge CLK);
          chk("bp_req_ready", REQ_READY, 0);
          chk("bp_op_count", OP_COUNT, exp_op);
        end
        @(posedge CLK);
        #1 RSP_READY = 1'b1;
      end
    join
    wait_idle();
    chk("bp_second_lge", last_flags[4:2], 3'b100);
    chk("bp_second_tag", last_tag, 9);

    run_op(1, 4'd0, 8'd1, 8'd2, 2'b00, 4'd3);
    chk("illegal_flags", last_flags, 6'b100000);
    chk("illegal_tag", last_tag, 3);
    chk("illegal_res", last_res, 0);

    // Asynchronous reset while the multiply is in flight
    send(1, 4'd9, 8'd3, 8'd4, 2'b11, 4'd9);
    #2 RST = 1'b0;
    #1;
    chk("arst_ce", CE, 0);
    chk("arst_opa", OPA, 0);
    chk("arst_opb", OPB, 0);
    chk("arst_inp_valid", INP_VALID, 0);
    chk("arst_rsp_valid", RSP_VALID, 0);
    chk("arst_rsp_res", RSP_RES, 0);
    chk("arst_rsp_tag", RSP_TAG, 0);
    chk("arst_op_count", OP_COUNT, 0);
    chk("arst_err_count", ERR_COUNT, 0);
    chk("arst_req_ready", REQ_READY, 1);
    sb.delete();
    exp_op = 0;
    exp_err = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk("post_rst_rsp_valid", RSP_VALID, 0);
      chk("post_rst_ce", CE, 0);
    end
    run_op(1, 4'd0, 8'd10, 8'd20, 2'b11, 4'd10);
    chk("post_rst_res", last_res, 30);
    chk("post_rst_op_count", OP_COUNT, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
